// File: rtl/axis_packet_splitter_pkg.sv
// Shared types and helpers for the AXI-Stream packet splitter.
package axis_packet_splitter_pkg;

  typedef enum logic [1:0] {
    StStr = 2'd0,
    StOpe = 2'd1,
    StEnd = 2'd2,
    StErr = 2'd3
  } state_e;

  // Ceiling log2, never below 1 so single-channel builds still get a select bit.
  function automatic int unsigned log2w(input int unsigned n);
    int unsigned r;
    r = 1;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/axis_packet_splitter_if.sv
// AXI-Stream bundle; LANES > 1 carries concatenated per-channel streams.
interface axis_packet_splitter_if #(
  parameter int unsigned LANES      = 1,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned KEEP_WIDTH = 2,
  parameter int unsigned ID_WIDTH   = 1,
  parameter int unsigned DEST_WIDTH = 1,
  parameter int unsigned USER_WIDTH = 1
);
  logic [LANES*DATA_WIDTH-1:0] tdata;
  logic [LANES*KEEP_WIDTH-1:0] tkeep;
  logic [LANES-1:0]            tvalid;
  logic [LANES-1:0]            tready;
  logic [LANES-1:0]            tlast;
  logic [LANES*ID_WIDTH-1:0]   tid;
  logic [LANES*DEST_WIDTH-1:0] tdest;
  logic [LANES*USER_WIDTH-1:0] tuser;

  modport master (output tdata, tkeep, tvalid, tlast, tid, tdest, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tid, tdest, tuser, output tready);
endinterface

// File: rtl/axis_packet_splitter_priority_encoder.sv
// Priority encoder: reports the index of the lowest set bit.
module axis_packet_splitter_priority_encoder
  import axis_packet_splitter_pkg::*;
#(
  parameter int unsigned WIDTH = 2,
  localparam int unsigned IdxW = log2w(WIDTH)
) (
  input  logic [WIDTH-1:0] in_bits,
  output logic [IdxW-1:0]  index,
  output logic             valid
);

  always_comb begin
    index = '0;
    valid = 1'b0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (in_bits[i]) begin
        index = IdxW'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axis_packet_splitter.sv
// Splits one input packet into consecutive per-channel segments of programmed beat length.
module axis_packet_splitter
  import axis_packet_splitter_pkg::*;
#(
  parameter int unsigned CHANNELS    = 2,
  parameter int unsigned DATA_WIDTH  = 16,
  parameter bit          KEEP_ENABLE = (DATA_WIDTH > 8),
  parameter int unsigned KEEP_WIDTH  = KEEP_ENABLE ? (DATA_WIDTH + 7) / 8 : 1,
  parameter bit          ID_ENABLE   = 1'b0,
  parameter int unsigned ID_WIDTH    = ID_ENABLE ? 8 : 1,
  parameter bit          DEST_ENABLE = 1'b0,
  parameter int unsigned DEST_WIDTH  = DEST_ENABLE ? 8 : 1,
  parameter bit          USER_ENABLE = 1'b0,
  parameter int unsigned USER_WIDTH  = USER_ENABLE ? 8 : 1,
  parameter int unsigned LEN_WIDTH   = 8,
  parameter bit          ALLOW_LOCKS = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          operation_start,
  input  logic [CHANNELS-1:0]           use_channels,
  input  logic [CHANNELS*LEN_WIDTH-1:0] segment_len,
  input  logic                          lock,
  input  logic                          interrupt,
  output logic                          operation_busy,
  output logic                          operation_complete,
  output logic                          operation_error,
  output logic                          transmission,
  axis_packet_splitter_if.slave         s_axis,
  axis_packet_splitter_if.master        m_axis
);

  localparam int unsigned SelW = log2w(CHANNELS);

  state_e                        state_q, state_d;
  logic [CHANNELS-1:0]           mask_q, mask_d, sel_oh;
  logic [CHANNELS*LEN_WIDTH-1:0] len_q, len_d;
  logic [LEN_WIDTH-1:0]          cnt_q, cnt_d, len_sel;
  logic [SelW-1:0]               sel;
  logic                          sel_valid, locked, active, hs, seg_last, last_chan, zero_len;
  logic                          busy_q, complete_q, error_q, trans_q;

  axis_packet_splitter_priority_encoder #(.WIDTH(CHANNELS)) u_prio (
    .in_bits (mask_q),
    .index   (sel),
    .valid   (sel_valid)
  );

  always_comb begin
    sel_oh   = '0;
    len_sel  = '0;
    zero_len = 1'b0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      if (sel_valid && sel == SelW'(i)) begin
        sel_oh[i] = 1'b1;
        len_sel   = len_q[i*LEN_WIDTH +: LEN_WIDTH];
      end
      if (use_channels[i] && segment_len[i*LEN_WIDTH +: LEN_WIDTH] == '0) zero_len = 1'b1;
    end
  end

  assign locked    = ALLOW_LOCKS && lock;
  assign active    = (state_q == StOpe) && !locked && !interrupt;
  assign hs        = s_axis.tvalid && s_axis.tready;
  assign seg_last  = (cnt_q == len_sel - LEN_WIDTH'(1));
  assign last_chan = ((mask_q & ~sel_oh) == '0);

  // Zero-latency routing: only the selected lane sees valid; payload fans out to all.
  assign s_axis.tready = active && |(sel_oh & m_axis.tready);
  assign m_axis.tvalid = sel_oh & {CHANNELS{active && s_axis.tvalid}};
  assign m_axis.tlast  = sel_oh & {CHANNELS{seg_last || s_axis.tlast}};
  assign m_axis.tdata  = {CHANNELS{s_axis.tdata}};
  assign m_axis.tkeep  = KEEP_ENABLE ? {CHANNELS{s_axis.tkeep}} : '1;
  assign m_axis.tid    = ID_ENABLE ? {CHANNELS{s_axis.tid}} : '0;
  assign m_axis.tdest  = DEST_ENABLE ? {CHANNELS{s_axis.tdest}} : '0;
  assign m_axis.tuser  = USER_ENABLE ? {CHANNELS{s_axis.tuser}} : '0;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    if (interrupt) begin
      state_d = StStr;
      cnt_d   = '0;
    end else if (!locked) begin
      unique case (state_q)
        StStr, StEnd: begin
          if (operation_start) begin
            mask_d  = use_channels;
            len_d   = segment_len;
            cnt_d   = '0;
            state_d = (use_channels == '0 || zero_len) ? StErr : StOpe;
          end
        end
        StOpe: begin
          if (hs) begin
            if (seg_last) begin
              mask_d = mask_q & ~sel_oh;
              cnt_d  = '0;
              if (last_chan)          state_d = s_axis.tlast ? StEnd : StErr;
              else if (s_axis.tlast)  state_d = StErr;
            end else begin
              cnt_d = cnt_q + LEN_WIDTH'(1);
              if (s_axis.tlast) state_d = StErr;
            end
          end
        end
        StErr: state_d = StStr;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StStr;
      mask_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      complete_q <= 1'b0;
      error_q    <= 1'b0;
      trans_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      mask_q     <= mask_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      busy_q     <= (state_d == StOpe);
      complete_q <= (state_q == StOpe) && (state_d == StEnd);
      error_q    <= (state_d == StErr) && (state_q != StErr);
      trans_q    <= hs;
    end
  end

  assign operation_busy     = busy_q;
  assign operation_complete = complete_q;
  assign operation_error    = error_q;
  assign transmission       = trans_q;

endmodule

// File: tb/tb_axis_packet_splitter.sv
// Directed bench for axis_packet_splitter with a beat-list reference model.
`timescale 1ns/1ps
module tb_axis_packet_splitter;

  localparam int unsigned CH = 3;
  localparam int unsigned DW = 16;
  localparam int unsigned KW = 2;
  localparam int unsigned LW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic              operation_start, lock, interrupt;
  logic [CH-1:0]     use_channels;
  logic [CH*LW-1:0]  segment_len;
  logic              operation_busy, operation_complete, operation_error, transmission;

  axis_packet_splitter_if #(.LANES(1), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(1),
                            .DEST_WIDTH(1), .USER_WIDTH(1)) s_axis ();
  axis_packet_splitter_if #(.LANES(CH), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(1),
                            .DEST_WIDTH(1), .USER_WIDTH(1)) m_axis ();

  axis_packet_splitter #(.CHANNELS(CH), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
    .clk                (clk),
    .rst                (rst),
    .operation_start    (operation_start),
    .use_channels       (use_channels),
    .segment_len        (segment_len),
    .lock               (lock),
    .interrupt          (interrupt),
    .operation_busy     (operation_busy),
    .operation_complete (operation_complete),
    .operation_error    (operation_error),
    .transmission       (transmission),
    .s_axis             (s_axis),
    .m_axis             (m_axis)
  );

  typedef struct packed {
    logic [1:0]  lane;
    logic [15:0] data;
    logic        last;
  } beat_t;

  beat_t exp_q[$];
  int    n_vec = 0;
  int    n_miss = 0;
  int    n_cpl = 0;
  int    n_errp = 0;
  bit    mon_en = 1'b0;
  logic  prev_hs = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: walk the selected channels in ascending order, handing each its beat count;
  // the packet ends at input tlast, at the end of the last segment, or at an interrupt.
  task automatic model(input logic [2:0] use_m, input int l0, input int l1, input int l2,
                       input int tlast_at, input int intr_at, input int base,
                       output int ncons, output bit ecmp, output bit eerr);
    int lens[3];
    int total, b;
    lens[0] = l0; lens[1] = l1; lens[2] = l2;
    ncons = 0; ecmp = 1'b0; eerr = 1'b0; total = 0;
    for (int c = 0; c < 3; c++) begin
      if (use_m[c]) begin
        if (lens[c] == 0) eerr = 1'b1;
        total += lens[c];
      end
    end
    if (use_m == 3'b000 || eerr) begin
      eerr = 1'b1;
      return;
    end
    if (intr_at != 0)                           ncons = intr_at - 1;
    else if (tlast_at != 0 && tlast_at < total) begin ncons = tlast_at; eerr = 1'b1; end
    else if (tlast_at == total)                 begin ncons = total;    ecmp = 1'b1; end
    else                                        begin ncons = total;    eerr = 1'b1; end
    b = 0;
    for (int c = 0; c < 3; c++) begin
      if (use_m[c]) begin
        for (int k = 0; k < lens[c]; k++) begin
          b++;
          if (b <= ncons)
            exp_q.push_back('{lane: 2'(c), data: 16'(base + b),
                              last: (k == lens[c] - 1) || (b == tlast_at)});
        end
      end
    end
  endtask

  always @(negedge clk) begin
    logic          s_hs;
    logic [CH-1:0] m_hs;
    beat_t         e;
    if (mon_en) begin
      s_hs = s_axis.tvalid & s_axis.tready;
      m_hs = m_axis.tvalid & m_axis.tready;
      chk("hs_pairing", 32'(s_hs), 32'(|m_hs));
      chk("transmission", 32'(transmission), 32'(prev_hs));
      prev_hs = s_hs;
      if (!operation_busy) chk("idle_gate", {s_axis.tready, m_axis.tvalid}, 0);
      if (lock || interrupt) chk("hold_gate", {s_axis.tready, m_axis.tvalid}, 0);
      for (int i = 0; i < int'(CH); i++) begin
        if (m_hs[i]) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", 32'(i + 1), 0);
          end else begin
            e = exp_q.pop_front();
            chk("lane", 32'(i), 32'(e.lane));
            chk("data", 32'(m_axis.tdata[i*DW +: DW]), 32'(e.data));
            chk("tlast", 32'(m_axis.tlast[i]), 32'(e.last));
          end
        end
        if (s_axis.tvalid) begin
          chk("copy_data", 32'(m_axis.tdata[i*DW +: DW]), 32'(s_axis.tdata));
          chk("copy_keep", 32'(m_axis.tkeep[i*KW +: KW]), 32'(s_axis.tkeep));
        end
      end
      if (operation_complete) n_cpl++;
      if (operation_error) n_errp++;
    end
  end

  task automatic drive_beat(input int idx, input int nbeats, input int tlast_at, input int base);
    if (idx < nbeats) begin
      s_axis.tvalid = 1'b1;
      s_axis.tdata  = 16'(base + idx + 1);
      s_axis.tlast  = (idx + 1 == tlast_at);
    end else begin
      s_axis.tvalid = 1'b0;
      s_axis.tlast  = 1'b0;
    end
  endtask

  task automatic run_op(input logic [2:0] use_m, input int l0, input int l1, input int l2,
                        input int nbeats, input int tlast_at, input bit rnd,
                        input int lock_at, input int intr_at, input int base);
    int ncons, idx, lock_cnt, cyc, cpl0, err0;
    bit ecmp, eerr, intr_done, done;
    model(use_m, l0, l1, l2, tlast_at, intr_at, base, ncons, ecmp, eerr);
    cpl0 = n_cpl; err0 = n_errp;
    @(posedge clk); #1;
    operation_start = 1'b1;
    use_channels    = use_m;
    segment_len     = {8'(l2), 8'(l1), 8'(l0)};
    @(negedge clk);
    idx = 0; lock_cnt = 0; cyc = 0; intr_done = 1'b0;
    while ((idx < ncons || (intr_at != 0 && !intr_done)) && cyc < 200) begin
      @(posedge clk); #1;
      operation_start = 1'b0;
      drive_beat(idx, nbeats, tlast_at, base);
      m_axis.tready = rnd ? 3'($urandom) : 3'b111;
      lock = (lock_at != 0 && idx == lock_at - 1 && lock_cnt < 5);
      if (lock) lock_cnt++;
      interrupt = (intr_at != 0 && idx == intr_at - 1);
      @(negedge clk);
      if (cyc == 0) chk("busy_on", 32'(operation_busy), 1);
      if (s_axis.tvalid && s_axis.tready) idx++;
      if (interrupt) intr_done = 1'b1;
      cyc++;
    end
    done = (idx >= ncons) && (intr_at == 0 || intr_done);
    chk("finished_in_budget", 32'(done), 1);
    if (lock_at != 0) chk("lock_cycles", 32'(lock_cnt), 5);
    for (int p = 0; p < 4; p++) begin
      @(posedge clk); #1;
      operation_start = 1'b0;
      interrupt       = 1'b0;
      lock            = 1'b0;
      m_axis.tready   = 3'b111;
      drive_beat(idx, nbeats, tlast_at, base);
      @(negedge clk);
      if (p == 0) begin
        chk("complete_next_cycle", 32'(operation_complete), 32'(ecmp));
        chk("error_next_cycle", 32'(operation_error), 32'(eerr));
      end
    end
    chk("busy_off", 32'(operation_busy), 0);
    chk("complete_count", 32'(n_cpl - cpl0), 32'(ecmp));
    chk("error_count", 32'(n_errp - err0), 32'(eerr));
    chk("all_beats_seen", 32'(exp_q.size()), 0);
    exp_q.delete();
    @(posedge clk); #1;
    s_axis.tvalid = 1'b0;
    s_axis.tlast  = 1'b0;
  endtask

  initial begin
    int  nc;
    bit  ec, ee;
    logic [4:0] lasts;
    logic [9:0] lanes;
    rst = 1'b1;
    operation_start = 1'b0; lock = 1'b0; interrupt = 1'b0;
    use_channels = '0; segment_len = '0;
    s_axis.tvalid = 1'b0; s_axis.tdata = '0; s_axis.tlast = 1'b0; s_axis.tkeep = 2'b11;
    s_axis.tid = '0; s_axis.tdest = '0; s_axis.tuser = '0;
    m_axis.tready = 3'b111;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", 32'(operation_busy), 0);
    chk("rst_complete", 32'(operation_complete), 0);
    chk("rst_error", 32'(operation_error), 0);
    chk("rst_transmission", 32'(transmission), 0);
    chk("rst_tready", 32'(s_axis.tready), 0);

    // Pin the model against hand-derived beat lists.
    model(3'b101, 3, 0, 2, 5, 0, 0, nc, ec, ee);
    chk("model_s1_count", 32'(exp_q.size()), 5);
    for (int i = 0; i < 5; i++) begin
      lasts[i]         = exp_q[i].last;
      lanes[2*i +: 2]  = exp_q[i].lane;
    end
    chk("model_s1_lasts", 32'(lasts), 32'b10100);
    chk("model_s1_lanes", 32'(lanes), 32'b10_10_00_00_00);
    chk("model_s1_status", {nc[7:0], 6'b0, ec, ee}, {8'd5, 8'b10});
    exp_q.delete();
    model(3'b011, 2, 2, 0, 3, 0, 0, nc, ec, ee);
    chk("model_s2_status", {nc[7:0], 6'b0, ec, ee}, {8'd3, 8'b01});
    chk("model_s2_beat3", 32'({exp_q[2].lane, exp_q[2].last}), 32'b011);
    exp_q.delete();

    //     use     l0 l1 l2 beats tlast rnd lock intr base
    run_op(3'b101, 3, 0, 2, 5,    5,    0,  0,   0,   16'h1000);
    run_op(3'b011, 2, 2, 0, 4,    3,    0,  0,   0,   16'h2000);
    run_op(3'b001, 4, 0, 0, 6,    0,    0,  0,   0,   16'h3000);
    run_op(3'b011, 3, 3, 0, 6,    6,    1,  0,   0,   16'h4000);
    run_op(3'b011, 3, 3, 0, 6,    6,    1,  0,   0,   16'h4800);
    run_op(3'b001, 4, 0, 0, 4,    4,    0,  2,   0,   16'h5000);
    run_op(3'b001, 4, 0, 0, 4,    4,    0,  0,   2,   16'h6000);
    run_op(3'b000, 2, 2, 2, 2,    2,    0,  0,   0,   16'h7000);
    run_op(3'b011, 2, 0, 0, 2,    2,    0,  0,   0,   16'h7800);
    run_op(3'b110, 0, 1, 2, 3,    3,    0,  0,   0,   16'h8000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
